// File: rtl/spram_reader_pkg.sv
// Shared definitions for the single-port RAM reader: FSM state encodings
// and the depth of the output skid buffer.
package spram_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/spram_skid_buf.sv
// Two-entry FIFO that holds words returned by the RAM until the downstream
// consumer takes them. Push and pop in the same cycle are legal, also when full.
module spram_skid_buf
  import spram_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic [WIDTH-1:0] entry_data [BUF_DEPTH];

  generate
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] data_reg;

      // Each slot captures the pushed word when the write pointer selects it.
      always_ff @(posedge clock) begin
        if (reset_n) begin
          data_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= push_data;
        end
      end

      assign entry_data[gi] = data_reg;
    end
  endgenerate

  // Pointer and occupancy bookkeeping; the reader's credit scheme keeps count <= 2.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + 2'(push) - 2'(pop);
    end
  end

  assign head_data = entry_data[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/spram_reader.sv
// Streams LEN words out of a single-port RAM starting at BASE, presenting
// them in address order on a valid/ready stream with full backpressure.
module spram_reader
  import spram_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [DEPTH-1:0] base,
  input  logic [DEPTH:0]   len,
  output logic [DEPTH-1:0] ram_addr,
  output logic             ram_we,
  input  logic [WIDTH-1:0] ram_out,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [DEPTH:0] LEN_ZERO = '0;
  localparam logic [DEPTH:0] LEN_ONE  = (DEPTH+1)'(1);

  state_t           state_reg, state_next;
  logic [DEPTH-1:0] addr_reg;       // next address to read
  logic [DEPTH:0]   remaining_reg;  // reads still to be issued
  logic             inflight_reg;   // a RAM read returns data this cycle
  logic [1:0]       buf_count;
  logic [WIDTH-1:0] head_data;
  logic             accept, idle_issue, read_issue, issue, pop;
  logic [2:0]       occupancy_next;

  // The first read goes out in the same cycle the start is accepted, so the
  // first word is visible two cycles after start.
  assign accept     = (state_reg == ST_IDLE) && start;
  assign idle_issue = accept && (len != LEN_ZERO);

  // Buffer slots taken once this cycle's returning word lands and this cycle's
  // pop leaves. A new read is allowed only if its word is guaranteed a slot
  // even if the consumer stalls next cycle.
  assign occupancy_next = 3'(buf_count) + 3'(inflight_reg) - 3'(pop);
  assign read_issue     = (state_reg == ST_READ) && (occupancy_next < 3'd2);
  assign issue          = idle_issue || read_issue;

  assign ram_addr  = accept ? base : addr_reg;
  assign ram_we    = 1'b0;
  assign out_valid = (buf_count != 2'd0);
  assign out_data  = head_data;
  assign pop       = out_valid && out_ready;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_FINISH);

  spram_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight_reg),
    .push_data (ram_out),
    .pop       (pop),
    .head_data (head_data),
    .count     (buf_count)
  );

  // State register, address/remaining counters and the in-flight flag.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      inflight_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= issue;
      if (idle_issue) begin
        addr_reg      <= base + DEPTH'(1);
        remaining_reg <= len - LEN_ONE;
      end else if (read_issue) begin
        addr_reg      <= addr_reg + DEPTH'(1);
        remaining_reg <= remaining_reg - LEN_ONE;
      end
    end
  end

  // Next-state logic: finish once nothing is left to read, in flight or buffered.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (len == LEN_ZERO)     state_next = ST_FINISH;
          else if (len == LEN_ONE) state_next = ST_DRAIN;
          else                     state_next = ST_READ;
        end
      end
      ST_READ: begin
        if (read_issue && (remaining_reg == LEN_ONE)) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!inflight_reg && ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop)))
          state_next = ST_FINISH;
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spram_reader.sv
// Self-checking bench for spram_reader: a RAM model with one-cycle read
// latency plus a scoreboard of expected words computed as mem[(base+i) mod 16].
module tb_spram_reader;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int NWORDS = 16;

  logic             clock = 1'b0;
  logic             rst   = 1'b1;
  logic             start = 1'b0;
  logic [DEPTH-1:0] base  = '0;
  logic [DEPTH:0]   len   = '0;
  logic [DEPTH-1:0] ram_addr;
  logic             ram_we;
  logic [WIDTH-1:0] ram_out = '0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] ram_mem [NWORDS];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [WIDTH-1:0] got_q [$];
  int               got_cyc [$];
  int               done_cyc [$];
  int               busy_cnt, unstable, max_count, valid_during_done, start_cyc;

  spram_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_n   (rst),
    .start     (start),
    .base      (base),
    .len       (len),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_out   (ram_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  // Single-port RAM model: registered read, data valid one cycle after address.
  always @(posedge clock) ram_out <= ram_mem[ram_addr];

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  function automatic logic ready_for(input int mode, input int k);
    logic [7:0] pat;
    pat = 8'b0110_1001;  // bit k%8: 1,0,0,1,0,1,1,0
    case (mode)
      0:       return 1'b1;
      1:       return pat[k % 8];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] expected_word(input int b, input int i);
    return ram_mem[(b + i) % NWORDS];
  endfunction

  // Drives one burst and records what the stream delivered; checks live in the tests.
  task automatic run_burst(input int b, input int l, input int mode, input int hold_start);
    int               post_done;
    logic             prev_stall;
    logic [WIDTH-1:0] prev_data;
    got_q.delete(); got_cyc.delete(); done_cyc.delete();
    busy_cnt = 0; unstable = 0; max_count = 0; valid_during_done = 0;
    post_done = -1; prev_stall = 1'b0; prev_data = '0;
    start = 1'b1; base = DEPTH'(b); len = (DEPTH+1)'(l); start_cyc = cyc;
    out_ready = ready_for(mode, 0);
    for (int k = 0; k < 400 && post_done < 3; k++) begin
      step();
      start = (k < hold_start);
      base  = 4'd3;
      len   = 5'd7;
      out_ready = ready_for(mode, k + 1);
      if (prev_stall && (!out_valid || out_data !== prev_data)) unstable++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc.push_back(cyc);
        if (out_valid) valid_during_done++;
      end
      if (int'(dut.buf_count) > max_count) max_count = int'(dut.buf_count);
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_cyc.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (post_done >= 0) post_done++;
      else if (done) post_done = 0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_checks++; if (ram_addr !== 4'd0) $display("FAIL reset_ram_addr got %0d exp 0", ram_addr); else n_pass++;
    n_checks++; if (out_data !== 8'd0) $display("FAIL reset_out_data got %0d exp 0", out_data); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL reset_ram_we got %b exp 0", ram_we); else n_pass++;
    rst = 1'b0;
    step();
    $display("reset: outputs idle after reset");
  endtask

  task automatic test_full_stream();
    int gaps;
    for (int i = 0; i < NWORDS; i++) ram_mem[i] = 8'(i);
    run_burst(0, 16, 0, 0);
    n_checks++; if (got_q.size() != 16) $display("FAIL full_count got %0d exp 16", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < 16; i++) begin
      n_checks++;
      if (got_q[i] !== expected_word(0, i)) $display("FAIL full_word%0d got %0d exp %0d", i, got_q[i], expected_word(0, i));
      else n_pass++;
    end
    if (got_q.size() == 16) begin
      gaps = 0;
      for (int i = 0; i < 16; i++) if (got_cyc[i] != got_cyc[0] + i) gaps++;
      n_checks++; if (got_cyc[0] - start_cyc != 2) $display("FAIL full_latency got %0d exp 2", got_cyc[0] - start_cyc); else n_pass++;
      n_checks++; if (gaps != 0) $display("FAIL full_back_to_back got %0d gaps exp 0", gaps); else n_pass++;
      n_checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != got_cyc[15] + 1)
        $display("FAIL full_done_timing got %0d pulses first_at %0d exp 1 at %0d", done_cyc.size(),
                 (done_cyc.size() > 0) ? done_cyc[0] : -1, got_cyc[15] + 1);
      else n_pass++;
    end
    $display("full_stream: base 0 len 16 delivered %0d words", got_q.size());
  endtask

  task automatic test_wrap();
    run_burst(14, 4, 0, 0);
    n_checks++; if (got_q.size() != 4) $display("FAIL wrap_count got %0d exp 4", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      n_checks++;
      if (got_q[i] !== expected_word(14, i)) $display("FAIL wrap_word%0d got %0d exp %0d", i, got_q[i], expected_word(14, i));
      else n_pass++;
    end
    n_checks++;
    if (done_cyc.size() != 1 || busy_cnt != done_cyc[0] - start_cyc)
      $display("FAIL wrap_busy_span got %0d cycles (%0d done pulses) exp through done", busy_cnt, done_cyc.size());
    else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL wrap_busy_after got %b exp 0", busy); else n_pass++;
    $display("wrap: base 14 len 4 delivered %0d words", got_q.size());
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < NWORDS; i++) ram_mem[i] = 8'($urandom);
    run_burst(6, 5, 1, 0);
    n_checks++; if (got_q.size() != 5) $display("FAIL bp_count got %0d exp 5", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      n_checks++;
      if (got_q[i] !== expected_word(6, i)) $display("FAIL bp_word%0d got %0d exp %0d", i, got_q[i], expected_word(6, i));
      else n_pass++;
    end
    n_checks++; if (unstable != 0) $display("FAIL bp_stall_stable got %0d changes exp 0", unstable); else n_pass++;
    n_checks++; if (max_count > 2) $display("FAIL bp_buffer_max got %0d exp <=2", max_count); else n_pass++;
    n_checks++; if (valid_during_done != 0) $display("FAIL bp_valid_with_done got %0d exp 0", valid_during_done); else n_pass++;
    n_checks++; if (done_cyc.size() != 1) $display("FAIL bp_done_pulses got %0d exp 1", done_cyc.size()); else n_pass++;
    $display("backpressure: base 6 len 5 delivered %0d words", got_q.size());
  endtask

  task automatic test_empty();
    run_burst(9, 0, 0, 0);
    n_checks++; if (got_q.size() != 0) $display("FAIL empty_words got %0d exp 0", got_q.size()); else n_pass++;
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != start_cyc + 1)
      $display("FAIL empty_done got %0d pulses first_at %0d exp 1 at %0d", done_cyc.size(),
               (done_cyc.size() > 0) ? done_cyc[0] : -1, start_cyc + 1);
    else n_pass++;
    n_checks++; if (busy_cnt != 1) $display("FAIL empty_busy_cycles got %0d exp 1", busy_cnt); else n_pass++;
    $display("empty: len 0 busy for %0d cycles", busy_cnt);
  endtask

  task automatic test_start_while_busy();
    int bad;
    for (int i = 0; i < NWORDS; i++) ram_mem[i] = 8'($urandom);
    run_burst(10, 4, 2, 3);
    bad = 0;
    for (int i = 0; i < got_q.size() && i < 4; i++) if (got_q[i] !== expected_word(10, i)) bad++;
    n_checks++; if (got_q.size() != 4) $display("FAIL restart_count got %0d exp 4", got_q.size()); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL restart_words got %0d wrong exp 0", bad); else n_pass++;
    n_checks++; if (done_cyc.size() != 1) $display("FAIL restart_done_pulses got %0d exp 1", done_cyc.size()); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL restart_busy_after got %b exp 0", busy); else n_pass++;
    $display("start_while_busy: base 10 len 4 delivered %0d words", got_q.size());
  endtask

  task automatic test_reset_mid();
    int n, stray, bad;
    for (int i = 0; i < NWORDS; i++) ram_mem[i] = 8'(i + 8'h40);
    start = 1'b1; base = 4'd0; len = 5'd8; out_ready = 1'b1; n = 0;
    for (int k = 0; k < 50 && n < 3; k++) begin
      step();
      start = 1'b0;
      if (out_valid && out_ready) n++;
    end
    n_checks++; if (n != 3) $display("FAIL rmid_reach3 got %0d exp 3", n); else n_pass++;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else n_pass++;
    stray = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (out_valid || busy || done) stray++;
    end
    n_checks++; if (stray != 0) $display("FAIL rmid_stray got %0d exp 0", stray); else n_pass++;
    run_burst(5, 4, 2, 0);
    bad = 0;
    for (int i = 0; i < got_q.size() && i < 4; i++) if (got_q[i] !== expected_word(5, i)) bad++;
    n_checks++; if (got_q.size() != 4 || bad != 0) $display("FAIL rmid_fresh got %0d words %0d wrong exp 4 words 0 wrong", got_q.size(), bad); else n_pass++;
    $display("reset_mid: fresh burst base 5 delivered %0d words", got_q.size());
  endtask

  task automatic test_random();
    int b, l, bad;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NWORDS; i++) ram_mem[i] = 8'($urandom);
      b = $urandom_range(0, 15);
      l = $urandom_range(1, 16);
      run_burst(b, l, 2, 0);
      bad = 0;
      for (int i = 0; i < got_q.size() && i < l; i++) if (got_q[i] !== expected_word(b, i)) bad++;
      n_checks++;
      if (got_q.size() != l || bad != 0 || done_cyc.size() != 1 || max_count > 2 || unstable != 0)
        $display("FAIL rand%0d got %0d words %0d wrong %0d done max %0d unstable %0d exp %0d words 0 wrong 1 done",
                 t, got_q.size(), bad, done_cyc.size(), max_count, unstable, l);
      else n_pass++;
      $display("random: base %0d len %0d delivered %0d words", b, l, got_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) ram_mem[i] = '0;
    test_reset();
    test_full_stream();
    test_wrap();
    test_backpressure();
    test_empty();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
